// File: rtl/des_pkg.sv
// Shared DES tables, permutation helpers and state encoding for the DES cores.
// Bit numbering: DES bit n (1-based, MSB first) lives at vector index [W-n] of a [W-1:0] value.
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } des_state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

    localparam int FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Encrypt left-shift schedule; decryption walks it backwards as right rotations.
    localparam int ENC_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Row r of box s at index 4*s+r; column 0 is the most significant nibble.
    localparam logic [63:0] S_T [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    function automatic logic [63:0] perm_ip(input logic [63:0] din);
        logic [63:0] dout;
        dout = '0;
        for (int k = 0; k < 64; k++) dout[6'(63 - k)] = din[6'(64 - IP_T[k])];
        return dout;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] din);
        logic [63:0] dout;
        dout = '0;
        for (int k = 0; k < 64; k++) dout[6'(63 - k)] = din[6'(64 - FP_T[k])];
        return dout;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] din);
        logic [47:0] dout;
        dout = '0;
        for (int k = 0; k < 48; k++) dout[6'(47 - k)] = din[5'(32 - E_T[k])];
        return dout;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] din);
        logic [31:0] dout;
        dout = '0;
        for (int k = 0; k < 32; k++) dout[5'(31 - k)] = din[5'(32 - P_T[k])];
        return dout;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] din);
        logic [55:0] dout;
        dout = '0;
        for (int k = 0; k < 56; k++) dout[6'(55 - k)] = din[6'(64 - PC1_T[k])];
        return dout;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] din);
        logic [47:0] dout;
        dout = '0;
        for (int k = 0; k < 48; k++) dout[6'(47 - k)] = din[6'(56 - PC2_T[k])];
        return dout;
    endfunction

    function automatic logic [3:0] sbox(input logic [2:0] box, input logic [5:0] b);
        logic [63:0] rowv;
        rowv = S_T[{box, b[5], b[0]}];
        rowv = rowv >> {4'd15 - b[4:1], 2'b00};
        return rowv[3:0];
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        x = perm_e(r) ^ k;
        s = '0;
        for (int i = 0; i < 8; i++) s = {s[27:0], sbox(3'(i), 6'(x >> (42 - 6 * i)))};
        return perm_p(s);
    endfunction

    function automatic logic [27:0] rot_right28(input logic [27:0] v, input int amt);
        logic [27:0] res;
        res = v;
        if (amt == 1) res = {v[0], v[27:1]};
        else if (amt == 2) res = {v[1:0], v[27:2]};
        return res;
    endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: L' = R, R' = L xor f(R, K).
module des_round
    import des_pkg::*;
(
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [47:0] subkey,
    output logic [31:0] l_next,
    output logic [31:0] r_next
);

    always_comb begin
        l_next = r;
        r_next = l ^ des_f(r, subkey);
    end

endmodule

// File: rtl/des_decrypt.sv
// Iterative DES decryption: one Feistel round per clock, subkeys K16..K1 derived
// on the fly by rotating C/D right (PC1 output already equals C16/D16).
module des_decrypt
    import des_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [0:63] cipherText,
    input  logic [0:63] key,
    output logic [63:0] decrypted,
    output logic        completed,
    output logic        busy
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    des_state_t  state, next_state;
    logic [3:0]  round_cnt;
    logic [31:0] l_q, r_q, l_next, r_next;
    logic [27:0] c_q, d_q;
    logic [47:0] subkey;
    logic [63:0] ct_val, key_val, ip_val;
    logic [55:0] pc1_val;
    logic        accept, last_round;
    int          rot_amt;

    always_comb begin
        ct_val     = cipherText;
        key_val    = key;
        ip_val     = perm_ip(ct_val);
        pc1_val    = perm_pc1(key_val);
        subkey     = perm_pc2({c_q, d_q});
        accept     = start && (state != ST_ROUND);
        last_round = (state == ST_ROUND) && (round_cnt == LAST_ROUND);
        // After round i the key state steps back by DES round (17-i)'s shift.
        rot_amt    = ENC_SHIFT[4'd15 - round_cnt];
    end

    des_round u_round (
        .l      (l_q),
        .r      (r_q),
        .subkey (subkey),
        .l_next (l_next),
        .r_next (r_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) next_state = ST_ROUND;
            ST_ROUND:         if (round_cnt == LAST_ROUND) next_state = ST_DONE;
            default:          next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            round_cnt <= '0;
            decrypted <= '0;
            completed <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            l_q       <= ip_val[63:32];
            r_q       <= ip_val[31:0];
            c_q       <= pc1_val[55:28];
            d_q       <= pc1_val[27:0];
            round_cnt <= '0;
            completed <= 1'b0;
            busy      <= 1'b1;
        end else if (state == ST_ROUND) begin
            l_q       <= l_next;
            r_q       <= r_next;
            c_q       <= rot_right28(c_q, rot_amt);
            d_q       <= rot_right28(d_q, rot_amt);
            round_cnt <= round_cnt + 4'd1;
            if (last_round) begin
                // Halves are swapped back before the final permutation.
                decrypted <= perm_fp({r_next, l_next});
                completed <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_des_decrypt.sv
// Directed self-checking bench for des_decrypt: known-answer vectors, round trips,
// restart from DONE, ignored start, async reset abort and input stability.
module tb_des_decrypt;
    import des_pkg::*;

    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] K1P = 64'h123557799ABDDEF0;
    localparam logic [63:0] C1  = 64'h85E813540F0AB405;
    localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] C2  = 64'h0000000000000000;
    localparam logic [63:0] P2  = 64'h8787878787878787;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [0:63] cipher_text;
    logic [0:63] key_in;
    logic [63:0] decrypted;
    logic        completed;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    des_decrypt dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cipherText (cipher_text),
        .key        (key_in),
        .decrypted  (decrypted),
        .completed  (completed),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent forward DES used to build round-trip ciphertexts.
    function automatic logic [63:0] ref_encrypt(input logic [63:0] p, input logic [63:0] k);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] x;
        logic [31:0] l, r, t;
        cd = perm_pc1(k);
        c  = cd[55:28];
        d  = cd[27:0];
        x  = perm_ip(p);
        l  = x[63:32];
        r  = x[31:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < ENC_SHIFT[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            t = r;
            r = l ^ des_f(r, perm_pc2({c, d}));
            l = t;
        end
        return perm_fp({r, l});
    endfunction

    task automatic start_op(input logic [63:0] ct, input logic [63:0] k);
        @(negedge clk);
        start       = 1'b1;
        cipher_text = ct;
        key_in      = k;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after acceptance until completed; optional scrambling and stray start.
    task automatic wait_done(input bit scramble, input int inject_at, output int cycles);
        cycles = 0;
        while (!completed && cycles < 40) begin
            if (scramble) begin
                cipher_text = {$urandom, $urandom};
                key_in      = {$urandom, $urandom};
            end
            if (cycles == inject_at) begin
                start       = 1'b1;
                cipher_text = 64'hFFFF0000AAAA5555;
                key_in      = 64'h0123456789ABCDEF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
    endtask

    task automatic run_vector(input string name, input logic [63:0] ct, input logic [63:0] k,
                              input logic [63:0] exp_p, input bit scramble, input int inject_at);
        int cycles;
        start_op(ct, k);
        wait_done(scramble, inject_at, cycles);
        checks++;
        if (cycles !== 16) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles, expected 16", name, cycles);
        end
        checks++;
        if (decrypted !== exp_p) begin
            failures++;
            $display("FAIL %s data: got %h, expected %h", name, decrypted, exp_p);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy: got %b, expected 0", name, busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        cipher_text = '0;
        key_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({decrypted, completed, busy} !== 66'd0) begin
            failures++;
            $display("FAIL reset: got dec=%h c=%b b=%b, expected all 0", decrypted, completed, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_model_kat;
        checks++;
        if (ref_encrypt(P1, K1) !== C1) begin
            failures++;
            $display("FAIL model_kat: got %h, expected %h", ref_encrypt(P1, K1), C1);
        end
    endtask

    task automatic test_standard_vector;
        run_vector("vec1", C1, K1, P1, 1'b0, -1);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (completed !== 1'b1 || decrypted !== P1) begin
            failures++;
            $display("FAIL done_hold: got c=%b dec=%h, expected 1 %h", completed, decrypted, P1);
        end
    endtask

    task automatic test_restart_from_done;
        run_vector("vec2", C2, K2, P2, 1'b0, -1);
        start_op(C1, K1);
        checks++;
        if (completed !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_accept: got c=%b b=%b, expected 0 1", completed, busy);
        end
        begin
            int cycles;
            wait_done(1'b0, -1, cycles);
            checks++;
            if (cycles !== 16 || decrypted !== P1) begin
                failures++;
                $display("FAIL restart_result: got %0d cycles dec=%h, expected 16 %h", cycles, decrypted, P1);
            end
        end
    endtask

    task automatic test_round_trip;
        logic [63:0] pts [2];
        logic [63:0] keys [2];
        pts[0]  = 64'hFEDCBA9876543210;
        pts[1]  = 64'h00DCB00006543210;
        keys[0] = 64'h1122334455667788;
        keys[1] = 64'h8877665544332211;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                run_vector("round_trip", ref_encrypt(pts[i], keys[j]), keys[j], pts[i], 1'b0, -1);
    endtask

    task automatic test_start_while_busy;
        run_vector("busy_start", C1, K1, P1, 1'b0, 5);
    endtask

    task automatic test_mid_reset;
        start_op(C2, K2);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({decrypted, completed, busy} !== 66'd0) begin
            failures++;
            $display("FAIL mid_reset: got dec=%h c=%b b=%b, expected all 0", decrypted, completed, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_vector("after_reset", C1, K1, P1, 1'b0, -1);
    endtask

    task automatic test_input_stability;
        run_vector("scrambled", C1, K1, P1, 1'b1, -1);
        run_vector("parity", C1, K1P, P1, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_model_kat();
        test_standard_vector();
        test_restart_from_done();
        test_round_trip();
        test_start_while_busy();
        test_mid_reset();
        test_input_stability();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
